dsi_hs_rx_byte_aligner: RTL and testbench
=========================================

// Module: dsi_hs_rx_byte_aligner
//
// PURPOSE
// - Receive-side counterpart of the DSI HS lane serializer. Takes raw 8-bit words from a lane
//   deserializer (arbitrary bit phase), hunts the D-PHY HS sync byte and locks the bit offset.
// - Emits byte-aligned payload with a valid strobe to the DSI packet decoder, one instance per lane.
// - All logic runs in the byte (logic) clock domain.
//
// PARAMETERS
// - SYNC_BYTE       8'hB8  HS leader sync byte. Compared in the same bit order as rx_in (bit0 first on wire).
// - TIMEOUT_CYCLES  1024   HUNT cycles allowed after hs_active rises before sync_err; range 1..65535.
//
// PORTS
// - rx_clock_logic  in   1  byte clock. Single clock for the whole block.
// - rst             in   1  synchronous, active-high reset.
// - rx_in           in   8  raw deserialized word; bit0 = earliest received bit.
// - hs_active       in   1  lane is in HS mode (from the LP/HS detector). Level-sensitive.
// - byte_out        out  8  aligned payload byte.
// - byte_valid      out  1  byte_out valid this cycle. No backpressure.
// - sync_locked     out  1  alignment is locked (state LOCKED).
// - sync_err        out  1  sticky HUNT timeout flag. Cleared when hs_active falls or on rst.
// - bit_offset      out  3  locked bit offset k (0..7). Holds its last value outside LOCKED.
//
// BEHAVIOUR
// - Reset: all outputs 0, prev word register 0, state IDLE, timeout counter 0.
// - Window: win[15:0] = {rx_in, prev}, where prev is rx_in registered one cycle earlier.
//   Candidate at offset k is cand[k] = win[k+7:k], for k = 0..7.
// - IDLE: outputs low. hs_active=1 -> HUNT, with the counter cleared.
// - HUNT: on any candidate match, the lowest matching k is latched into bit_offset -> LOCKED.
//   The sync byte itself is never output. On no match the counter increments.
//   Counter == TIMEOUT_CYCLES-1 with no match -> ERR, and sync_err=1 from the next cycle.
// - LOCKED: every cycle, byte_out <= win[bit_offset+7:bit_offset] and byte_valid <= 1.
//   Latency: the byte completed by the rx_in word of cycle n appears on byte_out at cycle n+1.
//   The first valid byte is the one following the sync byte.
// - ERR: byte_valid=0. Waits for hs_active=0.
// - hs_active=0 in any state -> IDLE next cycle. byte_valid and sync_locked are 0 from that cycle on.
//   sync_err is cleared in the same cycle. No partial byte is flushed.
// - Simultaneous match and timeout in the same HUNT cycle: the match wins -> LOCKED, no sync_err.
// - The prev register updates every cycle regardless of state, so a sync that straddles the
//   HUNT entry word is still found.
// - rst mid-operation: immediately returns to the reset values. Any in-flight byte is dropped.
// - Counter width: $clog2(TIMEOUT_CYCLES+1). It saturates and does not wrap.
//
// CONFIGURATION
// - DSI_RX_SYNC_TOLERANT_EN defined:
//   - HUNT also accepts a candidate at Hamming distance 1 from SYNC_BYTE (D-PHY sync error tolerance).
//   - An exact match at any offset has priority over 1-bit matches. Ties are resolved to the lowest k.
// - DSI_RX_SYNC_TOLERANT_EN undefined: exact match only. Distance-1 candidates are ignored.
//
// TESTING
// - Offset 0: words 00,00,B8,12,34, hs_active=1 -> LOCKED after B8, bit_offset=0, byte_out 12 then 34.
// - Offset 3: words 00,C0,x5,... carrying B8 at k=3, followed by 12,34 shifted by 3 ->
//   bit_offset=3, byte_out 12 then 34.
// - Timeout: TIMEOUT_CYCLES=16, constant 00 words -> sync_err=1 after 16 HUNT cycles, byte_valid stays 0.
//   hs_active=0 -> sync_err=0 next cycle.
// - Exit: hs_active drops while LOCKED -> byte_valid=0 and sync_locked=0 next cycle.
//   A re-entry with sync at k=5 relocks with bit_offset=5.
// - Tolerant: word BA (1 bit off) at k=0. Macro defined -> LOCKED, bit_offset=0.
//   Macro undefined -> stays in HUNT.
// - Reset mid-LOCKED: rst=1 for 1 cycle -> all outputs 0 and state IDLE.
//   Relock occurs only after a new sync byte.

Source files
------------

// File: rtl/dsi_hs_rx_byte_aligner.sv
// DSI HS receive byte aligner: hunts the HS sync byte in a raw deserialized stream and locks its bit offset.
// Optional macro DSI_RX_SYNC_TOLERANT_EN also accepts a sync byte with a single flipped bit.
module dsi_hs_rx_byte_aligner #(
    parameter logic [7:0] SYNC_BYTE      = 8'hB8,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       rx_clock_logic,
    input  logic       rst,
    input  logic [7:0] rx_in,
    input  logic       hs_active,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       sync_locked,
    output logic       sync_err,
    output logic [2:0] bit_offset
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HUNT,
        ST_LOCKED,
        ST_ERR
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       prev_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       byte_out_reg, byte_out_next;
    logic             byte_valid_reg, byte_valid_next;
    logic             sync_locked_reg, sync_locked_next;
    logic             sync_err_reg, sync_err_next;
    logic [2:0]       bit_offset_reg, bit_offset_next;

    logic [15:0] win;
    logic [7:0]  exact_hit;
    logic [7:0]  tol_hit;
    logic [7:0]  sel_hit;
    logic        hit_any;
    logic [2:0]  hit_k;

    assign win = {rx_in, prev_reg};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cand
            logic [7:0] cand;
            assign cand          = win[gi+7:gi];
            assign exact_hit[gi] = (cand == SYNC_BYTE);
`ifdef DSI_RX_SYNC_TOLERANT_EN
            assign tol_hit[gi]   = ($countones(cand ^ SYNC_BYTE) == 1);
`else
            assign tol_hit[gi]   = 1'b0;
`endif
        end
    endgenerate

    // Exact matches at any offset outrank 1-bit matches; within a class the lowest k wins.
    always_comb begin
        sel_hit = (|exact_hit) ? exact_hit : tol_hit;
        hit_any = |sel_hit;
        hit_k   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (sel_hit[i]) begin
                hit_k = 3'(i);
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        byte_out_next    = byte_out_reg;
        byte_valid_next  = 1'b0;
        sync_locked_next = 1'b0;
        sync_err_next    = sync_err_reg;
        bit_offset_next  = bit_offset_reg;
        if (!hs_active) begin
            state_next    = ST_IDLE;
            sync_err_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next    = ST_HUNT;
                    cnt_next      = '0;
                    sync_err_next = 1'b0;
                end
                ST_HUNT: begin
                    if (hit_any) begin
                        state_next       = ST_LOCKED;
                        bit_offset_next  = hit_k;
                        sync_locked_next = 1'b1;
                    end else if (cnt_reg >= CNT_LAST) begin
                        state_next    = ST_ERR;
                        sync_err_next = 1'b1;
                    end else begin
                        // Leaving HUNT at CNT_LAST keeps the counter from ever wrapping.
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    byte_out_next    = win[bit_offset_reg +: 8];
                    byte_valid_next  = 1'b1;
                    sync_locked_next = 1'b1;
                end
                default: begin
                    state_next = ST_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge rx_clock_logic) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            prev_reg        <= '0;
            cnt_reg         <= '0;
            byte_out_reg    <= '0;
            byte_valid_reg  <= 1'b0;
            sync_locked_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
            bit_offset_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            prev_reg        <= rx_in;
            cnt_reg         <= cnt_next;
            byte_out_reg    <= byte_out_next;
            byte_valid_reg  <= byte_valid_next;
            sync_locked_reg <= sync_locked_next;
            sync_err_reg    <= sync_err_next;
            bit_offset_reg  <= bit_offset_next;
        end
    end

    assign byte_out    = byte_out_reg;
    assign byte_valid  = byte_valid_reg;
    assign sync_locked = sync_locked_reg;
    assign sync_err    = sync_err_reg;
    assign bit_offset  = bit_offset_reg;

endmodule

// File: tb/tb_dsi_hs_rx_byte_aligner.sv
// Bench for dsi_hs_rx_byte_aligner: streams are built as bit sequences and the expected
// lock point is found by searching the bit stream directly for the sync byte.
module tb_dsi_hs_rx_byte_aligner;

    localparam int         T    = 16;
    localparam logic [7:0] SYNC = 8'hB8;

    logic       clk = 1'b0;
    logic       rst;
    logic       hs_active;
    logic [7:0] rx_in;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       sync_locked;
    logic       sync_err;
    logic [2:0] bit_offset;

    int         total = 0;
    int         passed = 0;
    logic [7:0] words [0:31];
    logic [2:0] model_off = 3'd0;

    always #5 clk = ~clk;

    dsi_hs_rx_byte_aligner #(
        .SYNC_BYTE(SYNC),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .rx_clock_logic(clk),
        .rst(rst),
        .rx_in(rx_in),
        .hs_active(hs_active),
        .byte_out(byte_out),
        .byte_valid(byte_valid),
        .sync_locked(sync_locked),
        .sync_err(sync_err),
        .bit_offset(bit_offset)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [7:0] w, input logic h, input logic r);
        rx_in     = w;
        hs_active = h;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    // Bit p of the stream is bit (p%8) of word p/8; bit0 of a word is earliest on the wire.
    function automatic logic [7:0] get_byte(input int p);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = words[(p + i) / 8][(p + i) % 8];
        return b;
    endfunction

    task automatic put_byte(input int p, input logic [7:0] v);
        for (int i = 0; i < 8; i++) words[(p + i) / 8][(p + i) % 8] = v[i];
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < 32; i++) words[i] = rnd ? 8'($urandom) : 8'h00;
    endtask

    function automatic int match_kind(input logic [7:0] b);
        if (b == SYNC) return 2;
`ifdef DSI_RX_SYNC_TOLERANT_EN
        if ($countones(b ^ SYNC) == 1) return 1;
`endif
        return 0;
    endfunction

    // Hunt entered with word e: the search covers stream positions from 8*e upward, eight per
    // cycle, exact matches first within a cycle, for at most T cycles.
    task automatic find_lock(input int e, input int lmax, output int lc, output int lp, output int errc);
        lc = 0; lp = 0; errc = 0;
        for (int c = e + 1; c <= lmax && c <= e + T && lc == 0; c++) begin
            for (int kind = 2; kind >= 1 && lc == 0; kind--) begin
                for (int k = 0; k < 8 && lc == 0; k++) begin
                    if (match_kind(get_byte(8 * (c - 1) + k)) == kind) begin
                        lc = c;
                        lp = 8 * (c - 1) + k;
                    end
                end
            end
        end
        if (lc == 0 && e + T <= lmax) errc = e + T;
    endtask

    // Word 0 is sent with hs_active low, words 1..len with hs_active high (rst at cycle rcyc
    // when nonzero), then one cycle with hs_active low.
    task automatic run_scenario(input string name, input int len, input int rcyc);
        int  e, lc, lp, errc;
        bit  lk, vl, er;
        e = 1;
        find_lock(e, (rcyc > 0) ? rcyc - 1 : len, lc, lp, errc);
        drive(words[0], 1'b0, 1'b0);
        for (int c = 1; c <= len; c++) begin
            drive(words[c], 1'b1, (c == rcyc));
            if (c == rcyc) begin
                model_off = 3'd0;
                check($sformatf("%s c%0d rst_byte", name, c), byte_out, 8'h00);
                check($sformatf("%s c%0d rst_valid", name, c), {7'd0, byte_valid}, 8'd0);
                check($sformatf("%s c%0d rst_locked", name, c), {7'd0, sync_locked}, 8'd0);
                check($sformatf("%s c%0d rst_err", name, c), {7'd0, sync_err}, 8'd0);
                check($sformatf("%s c%0d rst_off", name, c), {5'd0, bit_offset}, 8'd0);
                e = rcyc + 1;
                find_lock(e, len, lc, lp, errc);
            end else begin
                lk = (lc != 0) && (c >= lc);
                vl = (lc != 0) && (c > lc);
                er = (errc != 0) && (c >= errc);
                if (lc != 0 && c == lc) model_off = 3'(lp % 8);
                check($sformatf("%s c%0d valid", name, c), {7'd0, byte_valid}, {7'd0, vl});
                check($sformatf("%s c%0d locked", name, c), {7'd0, sync_locked}, {7'd0, lk});
                check($sformatf("%s c%0d err", name, c), {7'd0, sync_err}, {7'd0, er});
                check($sformatf("%s c%0d offset", name, c), {5'd0, bit_offset}, {5'd0, model_off});
                if (vl) check($sformatf("%s c%0d byte", name, c), byte_out, get_byte(lp + 8 * (c - lc)));
            end
        end
        drive(8'($urandom), 1'b0, 1'b0);
        check($sformatf("%s exit valid", name), {7'd0, byte_valid}, 8'd0);
        check($sformatf("%s exit locked", name), {7'd0, sync_locked}, 8'd0);
        check($sformatf("%s exit err", name), {7'd0, sync_err}, 8'd0);
        check($sformatf("%s exit offset", name), {5'd0, bit_offset}, {5'd0, model_off});
        $display("scenario %s: lock_cycle=%0d offset=%0d err_cycle=%0d", name, lc, model_off, errc);
    endtask

    initial begin
        int p;
        rst = 1'b1; hs_active = 1'b0; rx_in = 8'h00;
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b1);
        check("reset byte_out", byte_out, 8'h00);
        check("reset valid", {7'd0, byte_valid}, 8'd0);
        check("reset locked", {7'd0, sync_locked}, 8'd0);
        check("reset err", {7'd0, sync_err}, 8'd0);
        check("reset offset", {5'd0, bit_offset}, 8'd0);

        fill(1'b0);
        put_byte(24, SYNC); put_byte(32, 8'h12); put_byte(40, 8'h34);
        run_scenario("offset0", 8, 0);
        check("offset0 k", {5'd0, bit_offset}, 8'd0);

        fill(1'b0);
        put_byte(19, SYNC); put_byte(27, 8'h12); put_byte(35, 8'h34);
        run_scenario("offset3", 8, 0);
        check("offset3 k", {5'd0, bit_offset}, 8'd3);

        fill(1'b0);
        run_scenario("timeout", 20, 0);

        fill(1'b0);
        put_byte(29, SYNC); put_byte(37, 8'h5A); put_byte(45, 8'hC3);
        run_scenario("reentry_k5", 9, 0);
        check("reentry k", {5'd0, bit_offset}, 8'd5);

        fill(1'b0);
        put_byte(24, 8'hBA); put_byte(32, 8'h77);
        run_scenario("tolerant", 8, 0);

        fill(1'b0);
        put_byte(24, SYNC); put_byte(32, 8'h12); put_byte(40, 8'h34);
        put_byte(74, SYNC); put_byte(82, 8'h56); put_byte(90, 8'h9E);
        run_scenario("reset_mid", 14, 7);
        check("reset_mid relock k", {5'd0, bit_offset}, 8'd2);

        for (int n = 0; n < 8; n++) begin
            fill(1'b1);
            if (n % 4 != 3) begin
                p = $urandom_range(8, 8 * 17);
                put_byte(p, SYNC);
                for (int j = 1; j <= 5; j++) put_byte(p + 8 * j, 8'($urandom));
            end
            run_scenario($sformatf("rand%0d", n), 24, (n == 5) ? $urandom_range(6, 12) : 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
